ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter BITS, default 8, SHALL set the data word width in bits.
REQ-002 Parameter N, default 1024, SHALL set the RAM depth; AW = $clog2(N).
REQ-003 Parameter REQS, default 4, SHALL set the number of requesters (2..8); RW = $clog2(REQS).
REQ-004 clk  in  1  SHALL be the single clock; every register samples on its rising edge.
REQ-005 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-006 req_valid  in  REQS  SHALL carry the per-requester request-valid bits.
REQ-007 req_we  in  REQS  SHALL mark each request as a write (1) or a read (0).
REQ-008 req_addr  in  REQS*AW  SHALL carry the packed addresses; requester i uses slice [i*AW +: AW].
REQ-009 req_wdata  in  REQS*BITS  SHALL carry the packed write data; requester i uses slice [i*BITS +: BITS].
REQ-010 req_ready  out  REQS  SHALL be the per-requester grant; a request is accepted when valid & ready.
REQ-011 rsp_valid  out  REQS  SHALL flag read data returning to requester i.
REQ-012 rsp_data  out  REQS*BITS  SHALL carry the packed read data, valid only where rsp_valid[i]=1.
REQ-013 ram_we1/ram_we2  out  1  SHALL drive the write enables of RAM ports 1 and 2.
REQ-014 ram_write_addr1/2  out  AW; ram_write_data1/2  out  BITS  SHALL drive the RAM write address and data.
REQ-015 ram_read_addr1/2  out  AW  SHALL drive the RAM read addresses.
REQ-016 ram_read_data1/2  in  BITS  SHALL take the registered RAM outputs, which have 1-cycle latency.
REQ-017 collision_count  out  16  SHALL count deferred write-write collisions; it saturates at 16'hFFFF.

Function
REQ-018 Arbitration and grant outputs:
  - Each cycle the block SHALL grant at most two requests, chosen round-robin starting at rr_ptr.
  - The first valid requester at or after rr_ptr (modulo REQS) SHALL get RAM port 1.
  - The next valid requester SHALL get RAM port 2.
REQ-019 req_ready SHALL be combinational from req_valid and rr_ptr; requesters SHALL NOT make req_valid depend on req_ready.
REQ-020 A valid request not granted SHALL see req_ready=0 and SHALL hold its request stable until granted.
REQ-021 Write-write collision:
  - If both candidates are writes to the same address, only the port-1 candidate SHALL be granted that cycle.
  - The port-2 candidate SHALL get no grant; no third requester is substituted.
  - collision_count SHALL increment by 1 that cycle.
REQ-022 Port driving:
  - Granted write: ram_weX=1, with the requester's address and data on ram_write_addrX and ram_write_dataX.
  - Granted read: ram_weX=0 and ram_read_addrX = the requester's address.
  - Unused port: ram_weX=0 and all address/data outputs = 0.
REQ-023 rr_ptr SHALL advance to (last granted index + 1) mod REQS on the clock edge after any grant; with no grant it SHALL hold.
REQ-024 For each port, the block SHALL register a tag {rd_valid, owner index RW bits}, set when a read is granted on that port.
REQ-025 Read response:
  - rsp_valid[owner] SHALL assert exactly one cycle after the read handshake.
  - rsp_data for that owner SHALL equal ram_read_dataX for the port used; both paths are combinational from the registered tag.
REQ-026 A read and a write to the same address granted in the same cycle SHALL return the pre-write data (read-before-write).
REQ-027 Only one request per requester SHALL be granted per cycle, so the two response ports never target the same requester.
REQ-028 Back-to-back grants every cycle SHALL be supported; throughput is 2 accesses per cycle when no collision occurs.
REQ-029 rsp_data slices with rsp_valid[i]=0 SHALL be 0.

Reset
REQ-030 While reset=1:
  - rr_ptr=0, both tags=0, collision_count=0.
  - req_ready=0, rsp_valid=0, ram_we1=ram_we2=0.
REQ-031 Reset asserted mid-operation SHALL suppress any rsp_valid due the next cycle; RAM contents are not cleared.

Verification
REQ-032 After reset, write of 8'hA5 by requester 0 to address 5, then read of address 5 by requester 2 -> rsp_valid[2]=1 one cycle after the read grant, rsp_data slice 2 = 8'hA5.
REQ-033 All 4 requesters hold reads continuously from rr_ptr=0 -> grants {0,1}, then {2,3}, then {0,1}; every rsp_valid follows its grant by exactly one cycle.
REQ-034 Requesters 1 and 2 write address 7 in the same cycle (rr_ptr=0) -> only requester 1 granted, collision_count=1; requester 2 granted the next cycle; a later read of address 7 returns requester 2's data.
REQ-035 Same cycle: read of address 3 (holding 8'h11) and write of 8'h22 to address 3 -> rsp_data = 8'h11; a read the following cycle returns 8'h22.
REQ-036 Reset asserted in the cycle after a read grant -> rsp_valid stays 0 and rr_ptr returns to 0.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-port RAM arbiter: round-robin grants up to two requesters per cycle
// and routes registered read data back to the owning requester.
module ram_port_arbiter #(
  parameter  int BITS = 8,
  parameter  int N    = 1024,
  parameter  int REQS = 4,
  localparam int AW   = $clog2(N),
  localparam int RW   = $clog2(REQS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REQS-1:0]      req_valid,
  input  logic [REQS-1:0]      req_we,
  input  logic [REQS*AW-1:0]   req_addr,
  input  logic [REQS*BITS-1:0] req_wdata,
  output logic [REQS-1:0]      req_ready,
  output logic [REQS-1:0]      rsp_valid,
  output logic [REQS*BITS-1:0] rsp_data,
  output logic                 ram_we1,
  output logic                 ram_we2,
  output logic [AW-1:0]        ram_write_addr1,
  output logic [AW-1:0]        ram_write_addr2,
  output logic [BITS-1:0]      ram_write_data1,
  output logic [BITS-1:0]      ram_write_data2,
  output logic [AW-1:0]        ram_read_addr1,
  output logic [AW-1:0]        ram_read_addr2,
  input  logic [BITS-1:0]      ram_read_data1,
  input  logic [BITS-1:0]      ram_read_data2,
  output logic [15:0]          collision_count
);

  logic [RW-1:0] r_rr_ptr;
  logic          r_t1_v;
  logic [RW-1:0] r_t1_own;
  logic          r_t2_v;
  logic [RW-1:0] r_t2_own;
  logic [15:0]   r_coll;

  logic          w_p1_ok;
  logic          w_p2_ok;
  logic [RW-1:0] w_p1;
  logic [RW-1:0] w_p2;
  logic [RW-1:0] w_idx;
  logic [AW-1:0] w_a1;
  logic [AW-1:0] w_a2;
  logic          w_coll;
  logic          w_g2;

  function automatic logic [RW-1:0] wrap(input int v);
    return RW'(v % REQS);
  endfunction

  // Scan from rr_ptr: first valid takes port 1, second takes port 2.
  always_comb begin
    w_p1_ok = 1'b0;
    w_p2_ok = 1'b0;
    w_p1    = '0;
    w_p2    = '0;
    w_idx   = '0;
    for (int k = 0; k < REQS; k++) begin
      w_idx = wrap(int'(r_rr_ptr) + k);
      if (req_valid[w_idx] && !reset) begin
        if (!w_p1_ok) begin
          w_p1_ok = 1'b1;
          w_p1    = w_idx;
        end else if (!w_p2_ok) begin
          w_p2_ok = 1'b1;
          w_p2    = w_idx;
        end
      end
    end
  end

  assign w_a1   = req_addr[w_p1*AW +: AW];
  assign w_a2   = req_addr[w_p2*AW +: AW];
  assign w_coll = w_p1_ok && w_p2_ok && req_we[w_p1]
                  && req_we[w_p2] && (w_a1 == w_a2);
  assign w_g2   = w_p2_ok && !w_coll;

  always_comb begin
    req_ready       = '0;
    ram_we1         = 1'b0;
    ram_we2         = 1'b0;
    ram_write_addr1 = '0;
    ram_write_addr2 = '0;
    ram_write_data1 = '0;
    ram_write_data2 = '0;
    ram_read_addr1  = '0;
    ram_read_addr2  = '0;
    if (w_p1_ok) begin
      req_ready[w_p1] = 1'b1;
      if (req_we[w_p1]) begin
        ram_we1         = 1'b1;
        ram_write_addr1 = w_a1;
        ram_write_data1 = req_wdata[w_p1*BITS +: BITS];
      end else begin
        ram_read_addr1 = w_a1;
      end
    end
    if (w_g2) begin
      req_ready[w_p2] = 1'b1;
      if (req_we[w_p2]) begin
        ram_we2         = 1'b1;
        ram_write_addr2 = w_a2;
        ram_write_data2 = req_wdata[w_p2*BITS +: BITS];
      end else begin
        ram_read_addr2 = w_a2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= '0;
      r_t1_v   <= 1'b0;
      r_t1_own <= '0;
      r_t2_v   <= 1'b0;
      r_t2_own <= '0;
      r_coll   <= '0;
    end else begin
      if (w_g2)
        r_rr_ptr <= wrap(int'(w_p2) + 1);
      else if (w_p1_ok)
        r_rr_ptr <= wrap(int'(w_p1) + 1);
      r_t1_v   <= w_p1_ok && !req_we[w_p1];
      r_t1_own <= w_p1;
      r_t2_v   <= w_g2 && !req_we[w_p2];
      r_t2_own <= w_p2;
      if (w_coll && r_coll != 16'hFFFF)
        r_coll <= r_coll + 16'd1;
    end
  end

  // Reset gates responses that were already tagged on the previous edge.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (r_t1_v && !reset) begin
      rsp_valid[r_t1_own]            = 1'b1;
      rsp_data[r_t1_own*BITS +: BITS] = ram_read_data1;
    end
    if (r_t2_v && !reset) begin
      rsp_valid[r_t2_own]            = 1'b1;
      rsp_data[r_t2_own*BITS +: BITS] = ram_read_data2;
    end
  end

  assign collision_count = r_coll;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a registered
// read-before-write dual-port RAM model.
module tb_ram_port_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_we;
  logic [39:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic        ram_we1, ram_we2;
  logic [9:0]  ram_write_addr1, ram_write_addr2;
  logic [7:0]  ram_write_data1, ram_write_data2;
  logic [9:0]  ram_read_addr1, ram_read_addr2;
  logic [7:0]  ram_read_data1, ram_read_data2;
  logic [15:0] collision_count;

  logic [7:0]  mem [1024];

  int errors = 0;
  int checks = 0;

  ram_port_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ram_we1(ram_we1), .ram_we2(ram_we2),
    .ram_write_addr1(ram_write_addr1),
    .ram_write_addr2(ram_write_addr2),
    .ram_write_data1(ram_write_data1),
    .ram_write_data2(ram_write_data2),
    .ram_read_addr1(ram_read_addr1),
    .ram_read_addr2(ram_read_addr2),
    .ram_read_data1(ram_read_data1),
    .ram_read_data2(ram_read_data2),
    .collision_count(collision_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_read_data1 <= mem[ram_read_addr1];
    ram_read_data2 <= mem[ram_read_addr2];
    if (ram_we1) mem[ram_write_addr1] <= ram_write_data1;
    if (ram_we2) mem[ram_write_addr2] <= ram_write_data2;
  end

  typedef struct {
    logic [3:0]  pre;
    logic [3:0]  v;
    logic [3:0]  we;
    logic [39:0] addr;
    logic [3:0]  rdy;
    logic [1:0]  wes;
    logic [9:0]  a1;
    logic [9:0]  a2;
    logic [7:0]  d1;
    logic [7:0]  d2;
    logic [15:0] cc;
  } vec_t;

  vec_t tbl [9];

  function automatic logic [39:0] mk(input logic [9:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset;
    reset     = 1'b1;
    req_valid = '0;
    req_we    = '0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  logic [39:0] D;
  logic [3:0]  s2_rdy [4];
  logic [3:0]  s2_rv  [4];
  logic [31:0] s2_rd  [4];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    reset     = 1'b1;
    req_valid = 4'b1111;
    req_we    = 4'b0101;
    D         = mk(10'd10, 10'd20, 10'd30, 10'd40);
    req_addr  = D;
    req_wdata = 32'hA3A2A1A0;
    tick;
    tick;
    #2;
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_rsp", rsp_valid, 4'b0000);
    chk("rst_we", {ram_we2, ram_we1}, 2'b00);
    chk("rst_cc", collision_count, 16'd0);

    tbl[0] = '{4'h0, 4'b0000, 4'b0000, D,
               4'b0000, 2'b00, 10'd0, 10'd0, 8'h00, 8'h00, 16'd0};
    tbl[1] = '{4'h0, 4'b1111, 4'b0000, D,
               4'b0011, 2'b00, 10'd10, 10'd20, 8'h00, 8'h00, 16'd0};
    tbl[2] = '{4'h0, 4'b1010, 4'b1000, D,
               4'b1010, 2'b10, 10'd20, 10'd40, 8'h00, 8'hA3, 16'd0};
    tbl[3] = '{4'b0100, 4'b1111, 4'b0000, D,
               4'b1001, 2'b00, 10'd40, 10'd10, 8'h00, 8'h00, 16'd0};
    tbl[4] = '{4'b0010, 4'b0011, 4'b0011, D,
               4'b0011, 2'b11, 10'd10, 10'd20, 8'hA0, 8'hA1, 16'd0};
    tbl[5] = '{4'h0, 4'b0110, 4'b0110,
               mk(10'd10, 10'd7, 10'd7, 10'd40),
               4'b0010, 2'b01, 10'd7, 10'd0, 8'hA1, 8'h00, 16'd1};
    tbl[6] = '{4'b0001, 4'b0001, 4'b0000, D,
               4'b0001, 2'b00, 10'd10, 10'd0, 8'h00, 8'h00, 16'd0};
    tbl[7] = '{4'h0, 4'b1001, 4'b1001,
               mk(10'd5, 10'd20, 10'd30, 10'd5),
               4'b0001, 2'b01, 10'd5, 10'd0, 8'hA0, 8'h00, 16'd1};
    tbl[8] = '{4'h0, 4'b0110, 4'b0100,
               mk(10'd10, 10'd7, 10'd7, 10'd40),
               4'b0110, 2'b10, 10'd7, 10'd7, 8'h00, 8'hA2, 16'd0};

    for (int n = 0; n < 9; n++) begin
      do_reset;
      req_wdata = 32'hA3A2A1A0;
      if (tbl[n].pre != 4'h0) begin
        req_valid = tbl[n].pre;
        req_we    = '0;
        req_addr  = D;
        tick;
      end
      req_valid = tbl[n].v;
      req_we    = tbl[n].we;
      req_addr  = tbl[n].addr;
      #2;
      chk($sformatf("v%0d_ready", n), req_ready, tbl[n].rdy);
      chk($sformatf("v%0d_we", n), {ram_we2, ram_we1}, tbl[n].wes);
      chk($sformatf("v%0d_wa1", n), ram_write_addr1,
          tbl[n].wes[0] ? tbl[n].a1 : 10'd0);
      chk($sformatf("v%0d_ra1", n), ram_read_addr1,
          tbl[n].wes[0] ? 10'd0 : tbl[n].a1);
      chk($sformatf("v%0d_wd1", n), ram_write_data1, tbl[n].d1);
      chk($sformatf("v%0d_wa2", n), ram_write_addr2,
          tbl[n].wes[1] ? tbl[n].a2 : 10'd0);
      chk($sformatf("v%0d_ra2", n), ram_read_addr2,
          tbl[n].wes[1] ? 10'd0 : tbl[n].a2);
      chk($sformatf("v%0d_wd2", n), ram_write_data2, tbl[n].d2);
      tick;
      req_valid = '0;
      #2;
      chk($sformatf("v%0d_cc", n), collision_count, tbl[n].cc);
    end

    // Write then read back through the response path
    do_reset;
    req_valid = 4'b0001;
    req_we    = 4'b0001;
    req_addr  = mk(10'd5, 10'd0, 10'd0, 10'd0);
    req_wdata = 32'h000000A5;
    #2;
    chk("s1_wr_ready", req_ready, 4'b0001);
    tick;
    req_valid = 4'b0100;
    req_we    = 4'b0000;
    req_addr  = mk(10'd0, 10'd0, 10'd5, 10'd0);
    #2;
    chk("s1_rd_ready", req_ready, 4'b0100);
    chk("s1_rd_addr", ram_read_addr1, 10'd5);
    tick;
    req_valid = '0;
    #2;
    chk("s1_rsp_valid", rsp_valid, 4'b0100);
    chk("s1_rsp_data", rsp_data, 32'h00A50000);
    tick;

    // Continuous reads from all four requesters
    mem[10] = 8'h50;
    mem[20] = 8'h51;
    mem[30] = 8'h52;
    mem[40] = 8'h53;
    s2_rdy = '{4'b0011, 4'b1100, 4'b0011, 4'b1100};
    s2_rv  = '{4'b0000, 4'b0011, 4'b1100, 4'b0011};
    s2_rd  = '{32'h0, 32'h00005150, 32'h53520000, 32'h00005150};
    do_reset;
    req_valid = 4'b1111;
    req_we    = 4'b0000;
    req_addr  = D;
    for (int c = 0; c < 4; c++) begin
      #2;
      chk($sformatf("s2_ready_c%0d", c), req_ready, s2_rdy[c]);
      chk($sformatf("s2_rsp_valid_c%0d", c), rsp_valid, s2_rv[c]);
      chk($sformatf("s2_rsp_data_c%0d", c), rsp_data, s2_rd[c]);
      tick;
    end
    req_valid = '0;

    // Write-write collision is deferred, later writer wins
    do_reset;
    req_valid = 4'b0110;
    req_we    = 4'b0110;
    req_addr  = mk(10'd10, 10'd7, 10'd7, 10'd40);
    req_wdata = 32'hA33231A0;
    #2;
    chk("s3_ready0", req_ready, 4'b0010);
    chk("s3_wd1_0", ram_write_data1, 8'h31);
    chk("s3_we2_0", ram_we2, 1'b0);
    tick;
    req_valid = 4'b0100;
    #2;
    chk("s3_cc1", collision_count, 16'd1);
    chk("s3_ready1", req_ready, 4'b0100);
    chk("s3_wd1_1", ram_write_data1, 8'h32);
    tick;
    req_valid = 4'b0001;
    req_we    = 4'b0000;
    req_addr  = mk(10'd7, 10'd0, 10'd0, 10'd0);
    #2;
    chk("s3_cc2", collision_count, 16'd1);
    tick;
    req_valid = '0;
    #2;
    chk("s3_rsp_valid", rsp_valid, 4'b0001);
    chk("s3_rsp_data", rsp_data, 32'h00000032);
    tick;

    // Read and write of the same address in one cycle
    mem[3] = 8'h11;
    do_reset;
    req_valid = 4'b0011;
    req_we    = 4'b0010;
    req_addr  = mk(10'd3, 10'd3, 10'd0, 10'd0);
    req_wdata = 32'h00002200;
    #2;
    chk("s4_ready", req_ready, 4'b0011);
    chk("s4_ports", {ram_we2, ram_read_addr1, ram_write_addr2},
        {1'b1, 10'd3, 10'd3});
    tick;
    req_valid = 4'b0001;
    req_we    = 4'b0000;
    #2;
    chk("s4_rsp_valid", rsp_valid, 4'b0001);
    chk("s4_rsp_old", rsp_data, 32'h00000011);
    tick;
    req_valid = '0;
    #2;
    chk("s4_rsp_new", rsp_data, 32'h00000022);
    tick;

    // Reset right after a read grant
    do_reset;
    req_valid = 4'b0010;
    req_we    = 4'b0000;
    req_addr  = D;
    #2;
    chk("s5_ready", req_ready, 4'b0010);
    tick;
    reset     = 1'b1;
    req_valid = 4'b1111;
    #2;
    chk("s5_rsp_valid", rsp_valid, 4'b0000);
    chk("s5_rst_ready", req_ready, 4'b0000);
    tick;
    reset = 1'b0;
    #2;
    chk("s5_ptr_ready", req_ready, 4'b0011);
    chk("s5_rsp_after", rsp_valid, 4'b0000);
    tick;
    req_valid = '0;
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
